present_enc_ctrl: RTL
=====================

# present_enc_ctrl

Sequencing controller for one PRESENT-80 encryption. It accepts a 64-bit plaintext and an 80-bit key over a valid/ready handshake. It then steps the round datapath and the key schedule together for 31 rounds, one round per clock, applies the final whitening key K32, and returns the ciphertext over a second valid/ready handshake. It owns the round counter that the key schedule XORs into its salt field, and it sits between the bus-side wrapper and the cipher datapath.

## Interface
- ROUNDS, 31, number of full rounds; 31 is the only value required to match PRESENT vectors.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  plaintext/key offered.
- in_ready  out  1  block can accept a job; high only in IDLE.
- in_pt  in  64  plaintext.
- in_key  in  80  cipher key; bit 79 is the MSB.
- out_valid  out  1  ciphertext available.
- out_ready  in  1  consumer accepts the ciphertext.
- out_ct  out  64  ciphertext; valid only while out_valid=1.
- busy  out  1  high in RUN or DONE.
- round  out  5  current round counter, 0 in IDLE, 1..31 in RUN.

## Operation
- Registers:
  - state_r (64)
  - key_r (80)
  - rnd_r (5)
  - FSM with states IDLE, RUN, DONE.
- Reset values (asynchronous, rst=0):
  - FSM=IDLE; state_r=0, key_r=0, rnd_r=0.
  - Outputs: in_ready=1, out_valid=0, out_ct=0, busy=0, round=0.
- IDLE:
  - in_ready=1.
  - On in_valid=1 the block loads state_r<=in_pt, key_r<=in_key, rnd_r<=1, and moves to RUN.
- RUN, one round per cycle with r=rnd_r:
  - rk = key_r[79:16].
  - state_r <= P(S(state_r ^ rk)).
    - S applies the PRESENT S-box to all 16 nibbles. The S-box maps 0..F to C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.
    - P moves bit i to bit (16*i) mod 63 for i<63; bit 63 stays at bit 63.
  - key_r <= update(key_r, r):
    - Rotate left by 61: t = {key_r[18:0], key_r[79:19]}.
    - t[79:76] = S(t[79:76]).
    - t[19:15] = t[19:15] ^ r[4:0].
  - rnd_r <= r+1.
  - If r==ROUNDS: go to DONE and hold rnd_r at ROUNDS instead of incrementing.
- DONE:
  - out_valid=1 and out_ct = state_r ^ key_r[79:16], i.e. whitening with K32. The output is combinational from registers and is stable while held.
  - On out_ready=1 go to IDLE: rnd_r<=0, out_valid falls on the next cycle.
- in_valid is ignored outside IDLE. A new job is never accepted in the same cycle as the output handshake.
- out_ct is forced to 0 whenever out_valid=0.
- The S-box is the team's shared 4-bit PRESENT S-box: 17 instances, 16 for the state and 1 for the key.

## Timing
- Input handshake completes on the edge where in_valid & in_ready = 1 (edge E0).
- The RUN edges are E1..E31. The edge where r==31 stores the round-31 result and K32.
- out_valid rises after E31: 31 cycles after the accept edge, latency 31.
- Output handshake completes on the first edge with out_valid & out_ready. in_ready is high from the next cycle.
- Minimum period per job is 33 cycles: accept, 31 rounds, 1 DONE cycle.
- out_valid, out_ct and busy hold indefinitely under out_ready=0.
- round output: 1 in the first RUN cycle, 31 in the last RUN cycle and through DONE, 0 in IDLE.
- Reset asserted mid-RUN or in DONE returns to the reset values immediately, with no output produced. After release the block accepts a new job on the first edge with in_valid=1.
- Counter width: r is 5 bits; at most ROUNDS=31 is XORed, with no wrap.

## Test plan
- Job 1: key=0, pt=0 -> out_ct=5579C1387B228445, with out_valid first high 31 cycles after the accept edge.
- Job 2: key=FFFFFFFFFFFFFFFFFFFF, pt=0 -> E72C46C0F5945049.
- Job 3: key=0, pt=FFFFFFFFFFFFFFFF -> A112FFC72F68417B.
- Job 4: key=all ones, pt=all ones -> 3333DCD3213210D2.
- Back-to-back jobs with in_valid held high:
  - in_ready must be low during RUN/DONE.
  - A second key/pt change during RUN must not alter the result.
  - out_ready held 0 for 10 cycles must keep out_valid/out_ct stable.
- Key schedule check in round 1 with key=0:
  - key_r after E1 = C0000000000000008000 (rk2 = C000000000000000).
  - round=1 during the first RUN cycle.
- Reset at round 15 (rst low for 1 cycle):
  - Immediately out_valid=0, busy=0, round=0, in_ready=1.
  - A subsequent job with key=0, pt=0 yields 5579C1387B228445.

Source files
------------

// File: rtl/present_enc_ctrl.sv
// PRESENT-80 encryption sequencer.
// Accepts one plaintext/key job, runs ROUNDS rounds (one per clock) with the
// key schedule advancing in lockstep, then presents the K32-whitened
// ciphertext until the consumer takes it.
//
// Handshake rule (both ports): a transfer happens on the rising edge where
// valid and ready are both 1. Valid is never withdrawn before that edge, and
// the data it qualifies is held stable while valid=1 and ready=0.

// Shared 4-bit PRESENT S-box.
module present_sbox (
    input  logic [3:0] x,
    output logic [3:0] y
);
    // S-box lookup: 0..F -> C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2
    always_comb begin
        y = 4'h0;
        unique case (x)
            4'h0: y = 4'hC;
            4'h1: y = 4'h5;
            4'h2: y = 4'h6;
            4'h3: y = 4'hB;
            4'h4: y = 4'h9;
            4'h5: y = 4'h0;
            4'h6: y = 4'hA;
            4'h7: y = 4'hD;
            4'h8: y = 4'h3;
            4'h9: y = 4'hE;
            4'hA: y = 4'hF;
            4'hB: y = 4'h8;
            4'hC: y = 4'h4;
            4'hD: y = 4'h7;
            4'hE: y = 4'h1;
            4'hF: y = 4'h2;
            default: y = 4'h0;
        endcase
    end
endmodule

module present_enc_ctrl #(
    parameter int ROUNDS = 31
) (
    input  logic        clk,
    input  logic        rst,        // asynchronous, active low
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_pt,
    input  logic [79:0] in_key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_ct,
    output logic        busy,
    output logic [4:0]  round,
    output logic [1:0]  fsm_state   // debug view of the controller state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    localparam logic [4:0] LAST_ROUND = ROUNDS[4:0];

    fsm_t        fsm_q;
    fsm_t        fsm_d;

    logic [63:0] state_r;
    logic [79:0] key_r;
    logic [4:0]  rnd_r;

    logic        load;
    logic        step;
    logic        done_ack;

    logic [63:0] rk;
    logic [63:0] sbox_in;
    logic [63:0] sbox_out;
    logic [63:0] perm_out;
    logic [79:0] key_rot;
    logic [3:0]  key_sbox_out;
    logic [79:0] key_next;

    // ---------------------------------------------------------------
    // Round datapath: addRoundKey, sBoxLayer, pLayer
    // ---------------------------------------------------------------
    assign rk      = key_r[79:16];
    assign sbox_in = state_r ^ rk;

    genvar g;
    generate
        for (g = 0; g < 16; g++) begin : g_state_sbox
            present_sbox u_sbox (
                .x (sbox_in[4*g +: 4]),
                .y (sbox_out[4*g +: 4])
            );
        end

        // Bit i lands at (16*i) mod 63; bit 63 is a fixed point.
        for (g = 0; g < 63; g++) begin : g_perm
            assign perm_out[(16*g) % 63] = sbox_out[g];
        end
    endgenerate

    assign perm_out[63] = sbox_out[63];

    // ---------------------------------------------------------------
    // Key schedule: rotate left 61, S-box the top nibble, salt with r
    // ---------------------------------------------------------------
    assign key_rot = {key_r[18:0], key_r[79:19]};

    present_sbox u_key_sbox (
        .x (key_rot[79:76]),
        .y (key_sbox_out)
    );

    assign key_next = {key_sbox_out, key_rot[75:20], key_rot[19:15] ^ rnd_r, key_rot[14:0]};

    // ---------------------------------------------------------------
    // Controller
    // ---------------------------------------------------------------

    // Controller state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q <= IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    // Next-state decode and handshake/output generation.
    always_comb begin
        fsm_d     = fsm_q;
        load      = 1'b0;
        step      = 1'b0;
        done_ack  = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        out_ct    = 64'h0;
        unique case (fsm_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load  = 1'b1;
                    fsm_d = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (rnd_r == LAST_ROUND) begin
                    fsm_d = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                // Final whitening with K32, which key_r holds after the last round.
                out_ct    = state_r ^ rk;
                if (out_ready) begin
                    done_ack = 1'b1;
                    fsm_d    = IDLE;
                end
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase
    end

    // Cipher state, round key and round counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= 64'h0;
            key_r   <= 80'h0;
            rnd_r   <= 5'd0;
        end else if (load) begin
            state_r <= in_pt;
            key_r   <= in_key;
            rnd_r   <= 5'd1;
        end else if (step) begin
            state_r <= perm_out;
            key_r   <= key_next;
            // Counter parks at the last round so DONE still reports it.
            if (rnd_r != LAST_ROUND) begin
                rnd_r <= rnd_r + 5'd1;
            end
        end else if (done_ack) begin
            rnd_r <= 5'd0;
        end
    end

    assign round     = rnd_r;
    assign fsm_state = fsm_q;

endmodule
